fnd_scan_ctrl: RTL
==================

# fnd_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode FND. It generates the 2-bit digit index that drives the digit-select mux and the matching active-low digit-common enables. Each digit change is preceded by a short all-off blanking window to suppress ghosting. Leading zeros can optionally be suppressed. It sits directly upstream of the digit mux and BCD-to-segment decoder, beside the 0–9999 digit splitter.

## Interface
- SCAN_DIV, 100000, clocks per digit slot (blank + show); ≥ 4.
- BLANK_CYCLES, 1000, all-off clocks at the start of each slot; 1 ≤ BLANK_CYCLES < SCAN_DIV.
- LZ_BLANK, 1, 1 = suppress leading zeros, 0 = always show all four digits.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_en  in  1  scan enable; 0 = display dark.
- i_1000, i_100, i_10, i_1  in  4 each  BCD digits, used only for leading-zero detection.
- o_counter  out  2  digit index to mux: 0 = ones … 3 = thousands.
- o_fnd_com  out  4  digit commons, active-low, bit n = digit n.
- o_frame  out  1  one-cycle pulse when o_counter wraps 3→0.

## Operation
- States:
  - IDLE: all digits off.
  - BLANK: all digits off, counting BLANK_CYCLES.
  - SHOW: one digit on, counting SCAN_DIV−BLANK_CYCLES.
- Reset values:
  - state = BLANK, o_counter = 0, slot counter = 0.
  - o_fnd_com = 4'b1111, o_frame = 0.
- Transitions:
  - Any state with i_en = 0 → IDLE on the next edge. The slot counter clears and o_counter holds.
  - IDLE with i_en = 1 → BLANK with counter 0. o_counter is unchanged (the same digit resumes).
  - BLANK, counter = BLANK_CYCLES−1 → SHOW with counter 0.
  - SHOW, counter = SCAN_DIV−BLANK_CYCLES−1 → BLANK with counter 0. o_counter increments modulo 4 on the same edge.
  - On the 3→0 increment, o_frame = 1 for exactly that one cycle.
- o_counter changes only on entry to BLANK, so the mux and decoder have settled before the commons turn on.
- o_fnd_com:
  - Registered.
  - Equals ~(4'b0001 << o_counter) in every SHOW cycle unless that digit is masked.
  - Equals 4'b1111 in BLANK and IDLE.
- Leading-zero mask (applies only when LZ_BLANK = 1):
  - Digit 3 is masked if i_1000 == 0.
  - Digit 2 is masked if i_1000 and i_100 are both 0.
  - Digit 1 is masked if i_1000, i_100 and i_10 are all 0.
  - Digit 0 is never masked.
  - The mask is re-evaluated every SHOW cycle, so value changes mid-slot take effect on the next edge.
- Slot counter width is $clog2(SCAN_DIV).

## Timing
- With i_en held at 1, one digit slot = SCAN_DIV clocks and one frame = 4·SCAN_DIV clocks.
- Latency from reset release (i_en = 1):
  - BLANK_CYCLES clocks all-off.
  - Then digit 0 commons go low on the edge entering SHOW.
- Within a slot, commons are low for exactly SCAN_DIV−BLANK_CYCLES clocks.
- Commons are never low in two digits in the same cycle.
- Commons are never low in the same cycle that o_counter changes.
- i_en falling: o_fnd_com = 1111 from the next edge, with no partial-slot extension.
- i_en toggling on consecutive cycles: IDLE/BLANK alternate; SHOW is never reached.
- Reset asserted mid-slot: all outputs go to their reset values immediately, without waiting for clk.

## Structure
- Package fnd_pkg holds:
  - the state enum (IDLE, BLANK, SHOW);
  - FND_COM_OFF = 4'b1111;
  - the digit index constants DIG_1 = 0, DIG_10 = 1, DIG_100 = 2, DIG_1000 = 3.
- Sub-module fnd_lz_mask: combinational. Inputs are the four BCD digits and LZ_BLANK; output is a 4-bit mask. It is reused by the segment decoder for dark-segment control.

## Test plan
All scenarios use SCAN_DIV = 8 and BLANK_CYCLES = 2.
- Reset release, i_en = 1, digits 9,8,7,6:
  - 2 clocks of com = 1111, then 6 clocks of com = 1110.
  - Then blank, then 1101, 1011, 0111.
  - o_frame pulses once at cycle 32.
- LZ_BLANK = 1, digits 0,0,4,2: slots 3 and 2 stay 1111 throughout; slots 1 and 0 light normally.
- Digits 0,0,0,0: only digit 0 lights (1110).
- i_en = 0 at the 3rd SHOW cycle of digit 1:
  - com = 1111 on the next edge and o_counter holds 1.
  - On re-enable, 2 blank clocks then digit 1 lights.
- Assert reset_n = 0 mid-SHOW between edges: com = 1111 and o_counter = 0 immediately.
- Mid-slot change of i_1000 from 5 to 0 while o_counter = 3: com goes to 1111 on the next edge.

Source files
------------

// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg
//
// Shared definitions for the 4-digit common-anode FND display path: the scan
// controller, the leading-zero mask and the segment decoder all import this.
//
// Contents:
//   fnd_state_e  - scan controller states (IDLE, BLANK, SHOW)
//   FND_COM_OFF  - value of the active-low digit commons with every digit dark
//   DIG_1..1000  - digit index constants as seen on the digit-select mux
//   fnd_com_for  - active-low common pattern that lights a single digit
// ---------------------------------------------------------------------------
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } fnd_state_e;

    localparam logic [3:0] FND_COM_OFF = 4'b1111;

    localparam logic [1:0] DIG_1    = 2'd0;
    localparam logic [1:0] DIG_10   = 2'd1;
    localparam logic [1:0] DIG_100  = 2'd2;
    localparam logic [1:0] DIG_1000 = 2'd3;

    // Commons are active-low, so lighting digit n means driving bit n low
    // and leaving the other three high.
    function automatic logic [3:0] fnd_com_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/fnd_lz_mask.sv
// ---------------------------------------------------------------------------
// fnd_lz_mask
//
// Combinational leading-zero mask for a 4-digit BCD value. A set mask bit
// means that digit must stay dark. Shared between the scan controller (to
// keep the common off) and the segment decoder (dark-segment control).
//
// Ports:
//   lz_blank    in   1  1 = suppress leading zeros, 0 = mask is all zero
//   digit_1000  in   4  thousands BCD digit
//   digit_100   in   4  hundreds BCD digit
//   digit_10    in   4  tens BCD digit
//   digit_1     in   4  ones BCD digit (never masked)
//   mask        out  4  bit n = 1 -> digit n is a suppressed leading zero
// ---------------------------------------------------------------------------
module fnd_lz_mask
    import fnd_pkg::*;
(
    input  logic       lz_blank,
    input  logic [3:0] digit_1000,
    input  logic [3:0] digit_100,
    input  logic [3:0] digit_10,
    input  logic [3:0] digit_1,
    output logic [3:0] mask
);

    logic zero_from_1000;
    logic zero_from_100;
    logic zero_from_10;

    // The ones digit is always shown (a value of 0 still displays "0"), so
    // it only rides along to keep the interface uniform with the decoder.
    logic unused_digit_1;
    assign unused_digit_1 = ^digit_1;

    // A digit is a leading zero only if it and every more significant digit
    // are zero, so each flag chains off the one above it.
    assign zero_from_1000 = (digit_1000 == 4'd0);
    assign zero_from_100  = zero_from_1000 && (digit_100 == 4'd0);
    assign zero_from_10   = zero_from_100  && (digit_10  == 4'd0);

    // Assemble the mask; with suppression disabled every digit is shown.
    always_comb begin
        mask = 4'b0000;
        if (lz_blank) begin
            mask[DIG_1000] = zero_from_1000;
            mask[DIG_100]  = zero_from_100;
            mask[DIG_10]   = zero_from_10;
            mask[DIG_1]    = 1'b0;
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// fnd_scan_ctrl
//
// Time-multiplexed scan controller for the 4-digit common-anode FND. Each
// digit slot is SCAN_DIV clocks long: BLANK_CYCLES clocks with every common
// off (lets the digit mux and segment decoder settle, suppresses ghosting),
// then the remaining clocks with the selected digit's common driven low.
// The digit index only advances on entry to a blank window.
//
// Parameters:
//   SCAN_DIV      clocks per digit slot (blank + show), >= 4
//   BLANK_CYCLES  all-off clocks at the start of each slot, 1..SCAN_DIV-1
//   LZ_BLANK      1 = suppress leading zeros, 0 = always show four digits
//
// Ports:
//   clk        in   1  system clock
//   reset_n    in   1  asynchronous active-low reset
//   i_en       in   1  scan enable, 0 = display dark
//   i_1000     in   4  thousands BCD digit (leading-zero detection only)
//   i_100      in   4  hundreds BCD digit
//   i_10       in   4  tens BCD digit
//   i_1        in   4  ones BCD digit
//   o_counter  out  2  digit index to the mux, 0 = ones .. 3 = thousands
//   o_fnd_com  out  4  active-low digit commons, bit n = digit n
//   o_frame    out  1  one-cycle pulse when o_counter wraps 3 -> 0
// ---------------------------------------------------------------------------
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZ_BLANK     = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_en,
    input  logic [3:0] i_1000,
    input  logic [3:0] i_100,
    input  logic [3:0] i_10,
    input  logic [3:0] i_1,
    output logic [1:0] o_counter,
    output logic [3:0] o_fnd_com,
    output logic       o_frame
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    // Terminal counts of the two phases of a slot; the counter restarts at
    // zero on every phase change.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);

    fnd_state_e       state;
    fnd_state_e       state_nx;
    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] slot_cnt_nx;
    logic [1:0]       counter_nx;
    logic [3:0]       com_nx;
    logic             frame_nx;

    logic [3:0]       lz_mask;
    logic [3:0]       show_com;

    fnd_lz_mask u_lz_mask (
        .lz_blank   (LZ_BLANK != 0),
        .digit_1000 (i_1000),
        .digit_100  (i_100),
        .digit_10   (i_10),
        .digit_1    (i_1),
        .mask       (lz_mask)
    );

    // Common pattern for the current digit during SHOW. The mask is looked
    // up live so that a digit value changing mid-slot lights or darkens the
    // digit from the very next edge.
    assign show_com = lz_mask[o_counter] ? FND_COM_OFF : fnd_com_for(o_counter);

    // Next-state logic. o_fnd_com is registered, so com_nx is the pattern
    // for the state being entered: an edge that lands in SHOW drives the
    // digit common low on that same edge, every other edge turns all off.
    // Dropping i_en wins over everything and leaves the digit index alone
    // so the same digit resumes after re-enable.
    always_comb begin
        state_nx    = state;
        slot_cnt_nx = slot_cnt;
        counter_nx  = o_counter;
        com_nx      = FND_COM_OFF;
        frame_nx    = 1'b0;

        if (!i_en) begin
            state_nx    = IDLE;
            slot_cnt_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx    = BLANK;
                    slot_cnt_nx = '0;
                end

                BLANK: begin
                    if (slot_cnt == BLANK_LAST) begin
                        state_nx    = SHOW;
                        slot_cnt_nx = '0;
                        com_nx      = show_com;
                    end else begin
                        slot_cnt_nx = slot_cnt + 1'b1;
                    end
                end

                SHOW: begin
                    if (slot_cnt == SHOW_LAST) begin
                        // The index moves only while entering BLANK, so the
                        // commons are already off when the mux switches.
                        state_nx    = BLANK;
                        slot_cnt_nx = '0;
                        counter_nx  = o_counter + 2'd1;
                        frame_nx    = (o_counter == DIG_1000);
                    end else begin
                        slot_cnt_nx = slot_cnt + 1'b1;
                        com_nx      = show_com;
                    end
                end

                default: begin
                    state_nx    = IDLE;
                    slot_cnt_nx = '0;
                end
            endcase
        end
    end

    // State and output registers. Reset is asynchronous so the display goes
    // dark immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BLANK;
            slot_cnt  <= '0;
            o_counter <= DIG_1;
            o_fnd_com <= FND_COM_OFF;
            o_frame   <= 1'b0;
        end else begin
            state     <= state_nx;
            slot_cnt  <= slot_cnt_nx;
            o_counter <= counter_nx;
            o_fnd_com <= com_nx;
            o_frame   <= frame_nx;
        end
    end

endmodule
